// File: rtl/width_gearbox.sv
// -----------------------------------------------------------------------------
// width_gearbox
//
// Packs a stream of IN_W-bit beats into OUT_W-bit words. Bits go out MSB-first
// with no gaps between beats. Both sides use valid/ready handshakes. A flush
// closes the current packet. The last word of a flushed packet is zero-padded
// in its LSBs, bits_out gives its count of meaningful MSBs, and last_out marks it.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A producer that raises valid holds its payload
// until that edge. ready may depend on state, but never on the same side's
// valid.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   valid_in / ready_in   input beat handshake
//   data_in   [IN_W]      input beat, bit IN_W-1 is the oldest
//   flush_in              close the packet; sampled when ready_in=1
//   valid_out / ready_out output word handshake
//   data_out  [OUT_W]     packed word, oldest bits in the MSBs
//   bits_out  [CW]        meaningful MSBs in data_out (OUT_W for full words)
//   last_out              final word of a flushed packet
// -----------------------------------------------------------------------------
module width_gearbox #(
    parameter int  IN_W  = 24,
    parameter int  OUT_W = 128,
    localparam int CW    = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             flush_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic [CW-1:0]    bits_out,
    output logic             last_out
);

    localparam int TW = OUT_W + IN_W;  // residue plus one incoming beat
    localparam int NW = CW + 1;        // holds fill + IN_W (< 2*OUT_W)

    // The residue is kept left-aligned. Bits below 'fill' are always zero, so a
    // new beat can be OR-ed in directly below the existing bits.
    logic [OUT_W-1:0] res_q;
    logic [CW-1:0]    fill_q;
    logic             flush_pend_q;

    logic             slot_free;
    logic             accept;
    logic             do_flush;
    logic [TW-1:0]    data_ext;
    logic [TW-1:0]    merged;
    logic [NW-1:0]    n_sum;
    logic [NW-1:0]    rem;
    logic             completes;
    logic [OUT_W-1:0] merged_top;
    logic [OUT_W-1:0] res_after_word;

    always_comb begin
        slot_free = ~valid_out | ready_out;
        ready_in  = ~flush_pend_q & slot_free;
        accept    = valid_in & ready_in;
        do_flush  = flush_in & ready_in;

        // Place the beat so its MSB lands directly below the fill bits.
        data_ext = TW'(data_in);
        merged   = {res_q, {IN_W{1'b0}}} | (data_ext << (OUT_W - int'(fill_q)));

        n_sum     = NW'(fill_q) + NW'(IN_W);
        completes = (n_sum >= NW'(OUT_W));
        rem       = n_sum - NW'(OUT_W);

        // The upper OUT_W bits are either the finished word or, when there is
        // no completion, the new left-aligned residue. The low IN_W bits carry
        // the leftover of a completed word, moved back up to the MSBs.
        merged_top     = merged[TW-1:IN_W];
        res_after_word = OUT_W'(merged[IN_W-1:0]) << (OUT_W - IN_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            bits_out     <= '0;
            last_out     <= 1'b0;
        end else if (flush_pend_q && slot_free) begin
            // Second half of a split flush: send the held residue as the tail.
            valid_out    <= 1'b1;
            data_out     <= res_q;
            bits_out     <= fill_q;
            last_out     <= 1'b1;
            res_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
        end else if (accept) begin
            if (completes) begin
                valid_out <= 1'b1;
                data_out  <= merged_top;
                bits_out  <= CW'(OUT_W);
                last_out  <= do_flush && (rem == '0);
                res_q     <= res_after_word;
                fill_q    <= CW'(rem);
                // A leftover still has to be sent after this word.
                if (do_flush && (rem != '0)) begin
                    flush_pend_q <= 1'b1;
                end
            end else if (do_flush) begin
                valid_out <= 1'b1;
                data_out  <= merged_top;
                bits_out  <= CW'(n_sum);
                last_out  <= 1'b1;
                res_q     <= '0;
                fill_q    <= '0;
            end else begin
                res_q  <= merged_top;
                fill_q <= CW'(n_sum);
                if (ready_out) begin
                    valid_out <= 1'b0;
                end
            end
        end else if (do_flush && (fill_q != '0)) begin
            valid_out <= 1'b1;
            data_out  <= res_q;
            bits_out  <= fill_q;
            last_out  <= 1'b1;
            res_q     <= '0;
            fill_q    <= '0;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_width_gearbox.sv
// -----------------------------------------------------------------------------
// tb_width_gearbox
//
// Directed bench for width_gearbox. The main instance uses the default 24->128
// configuration. Two further instances use 8->32 and 16->16. Expected words are
// hand-computed constants. Each one is pushed into a per-instance queue before
// its beats are sent. A monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_width_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance, 24 -> 128
    logic         m_valid_in, m_ready_in, m_flush_in, m_valid_out, m_ready_out, m_last_out;
    logic [23:0]  m_data_in;
    logic [127:0] m_data_out;
    logic [7:0]   m_bits_out;

    // instance a, 8 -> 32
    logic         a_valid_in, a_ready_in, a_flush_in, a_valid_out, a_ready_out, a_last_out;
    logic [7:0]   a_data_in;
    logic [31:0]  a_data_out;
    logic [5:0]   a_bits_out;

    // instance b, 16 -> 16
    logic         b_valid_in, b_ready_in, b_flush_in, b_valid_out, b_ready_out, b_last_out;
    logic [15:0]  b_data_in;
    logic [15:0]  b_data_out;
    logic [4:0]   b_bits_out;

    width_gearbox dut_m (
        .clk(clk), .rst_n(rst_n),
        .valid_in(m_valid_in), .ready_in(m_ready_in), .data_in(m_data_in), .flush_in(m_flush_in),
        .valid_out(m_valid_out), .ready_out(m_ready_out), .data_out(m_data_out),
        .bits_out(m_bits_out), .last_out(m_last_out)
    );

    width_gearbox #(.IN_W(8), .OUT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .valid_in(a_valid_in), .ready_in(a_ready_in), .data_in(a_data_in), .flush_in(a_flush_in),
        .valid_out(a_valid_out), .ready_out(a_ready_out), .data_out(a_data_out),
        .bits_out(a_bits_out), .last_out(a_last_out)
    );

    width_gearbox #(.IN_W(16), .OUT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in), .flush_in(b_flush_in),
        .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
        .bits_out(b_bits_out), .last_out(b_last_out)
    );

    // expected words: {data, bits, last}
    logic [136:0] m_exp_q[$];
    logic [38:0]  a_exp_q[$];
    logic [21:0]  b_exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic stall_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: ready_in never rose within budget (t=%0t)", name, $time);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_m
        logic [136:0] e;
        if (rst_n && m_valid_out && m_ready_out) begin
            if (m_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_unexpected: got %0h expected no word", {m_data_out, m_bits_out, m_last_out});
            end else begin
                e = m_exp_q.pop_front();
                chk("m_word", {m_data_out, m_bits_out, m_last_out}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_a
        logic [38:0] e;
        if (rst_n && a_valid_out && a_ready_out) begin
            if (a_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got %0h expected no word", {a_data_out, a_bits_out, a_last_out});
            end else begin
                e = a_exp_q.pop_front();
                chk("a_word", {a_data_out, a_bits_out, a_last_out}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [21:0] e;
        if (rst_n && b_valid_out && b_ready_out) begin
            if (b_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got %0h expected no word", {b_data_out, b_bits_out, b_last_out});
            end else begin
                e = b_exp_q.pop_front();
                chk("b_word", {b_data_out, b_bits_out, b_last_out}, e);
            end
        end
    end

    // ---------------- drivers ----------------
    // Each driver is entered just after a rising edge. It returns just after
    // the edge that accepted the beat.
    task automatic send_m(input logic [23:0] d, input logic f);
        int n = 0;
        m_valid_in = 1'b1; m_data_in = d; m_flush_in = f;
        @(negedge clk);
        while (!m_ready_in && n < 200) begin n++; @(negedge clk); end
        if (!m_ready_in) stall_fail("m_send");
        @(posedge clk); #1;
        m_valid_in = 1'b0; m_flush_in = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] d, input logic f);
        int n = 0;
        a_valid_in = 1'b1; a_data_in = d; a_flush_in = f;
        @(negedge clk);
        while (!a_ready_in && n < 200) begin n++; @(negedge clk); end
        if (!a_ready_in) stall_fail("a_send");
        @(posedge clk); #1;
        a_valid_in = 1'b0; a_flush_in = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] d, input logic f);
        int n = 0;
        b_valid_in = 1'b1; b_data_in = d; b_flush_in = f;
        @(negedge clk);
        while (!b_ready_in && n < 200) begin n++; @(negedge clk); end
        if (!b_ready_in) stall_fail("b_send");
        @(posedge clk); #1;
        b_valid_in = 1'b0; b_flush_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [127:0] e_w0;
        rst_n = 1'b0;
        m_valid_in = 0; m_flush_in = 0; m_data_in = '0; m_ready_out = 1;
        a_valid_in = 0; a_flush_in = 0; a_data_in = '0; a_ready_out = 1;
        b_valid_in = 0; b_flush_in = 0; b_data_in = '0; b_ready_out = 1;

        // reset state
        #12;
        chk("rst_valid_out", m_valid_out, 1'b0);
        chk("rst_data_out",  m_data_out,  128'h0);
        chk("rst_bits_out",  m_bits_out,  8'd0);
        chk("rst_last_out",  m_last_out,  1'b0);
        chk("rst_ready_in",  m_ready_in,  1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // steady pack: beats 1..16 give three words with residues 16, 8, 0
        m_exp_q.push_back({128'h000001_000002_000003_000004_000005_00, 8'd128, 1'b0});
        m_exp_q.push_back({128'h0006_000007_000008_000009_00000A_0000, 8'd128, 1'b0});
        m_exp_q.push_back({128'h0B_00000C_00000D_00000E_00000F_000010, 8'd128, 1'b0});
        for (int i = 1; i <= 16; i++) send_m(24'(i), 1'b0);
        idle(2);

        // short flush: two beats, flush with the second
        m_exp_q.push_back({48'hAAAAAABBBBBB, 80'h0, 8'd48, 1'b1});
        send_m(24'hAAAAAA, 1'b0);
        send_m(24'hBBBBBB, 1'b1);
        idle(2);

        // split flush: fill=120, then a flushing beat leaves a 16-bit residue
        m_exp_q.push_back({128'hC00001_C00002_C00003_C00004_C00005_DD, 8'd128, 1'b0});
        m_exp_q.push_back({16'hEEFF, 112'h0, 8'd16, 1'b1});
        for (int i = 1; i <= 5; i++) send_m(24'hC00000 + 24'(i), 1'b0);
        send_m(24'hDDEEFF, 1'b1);
        @(negedge clk);
        chk("split_ready_in_blocked", m_ready_in, 1'b0);
        @(negedge clk);
        chk("split_ready_in_back", m_ready_in, 1'b1);
        @(posedge clk); #1;

        // flush with fill=0 and no beat: no word
        m_flush_in = 1'b1;
        @(posedge clk); #1;
        m_flush_in = 1'b0;
        @(negedge clk);
        chk("empty_flush_valid_out_0", m_valid_out, 1'b0);
        @(negedge clk);
        chk("empty_flush_valid_out_1", m_valid_out, 1'b0);
        @(posedge clk); #1;

        // backpressure: word held for 5 cycles while a beat waits
        e_w0 = 128'hE00001_E00002_E00003_E00004_E00005_E0;
        m_exp_q.push_back({e_w0, 8'd128, 1'b0});
        m_exp_q.push_back({128'h0006_E00007_E00008_E00009_E0000A_E000, 8'd128, 1'b0});
        m_exp_q.push_back({128'h0B_E0000C_E0000D_E0000E_E0000F_E00010, 8'd128, 1'b0});
        m_ready_out = 1'b0;
        for (int i = 1; i <= 6; i++) send_m(24'hE00000 + 24'(i), 1'b0);
        m_valid_in = 1'b1;
        m_data_in  = 24'hE00007;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_out", m_valid_out, 1'b1);
            chk("bp_ready_in",  m_ready_in,  1'b0);
            chk("bp_data_out",  m_data_out,  e_w0);
        end
        @(posedge clk); #1;
        m_ready_out = 1'b1;
        for (int i = 7; i <= 16; i++) send_m(24'hE00000 + 24'(i), 1'b0);
        idle(2);

        // reset with a residue pending and a word held
        m_ready_out = 1'b0;
        for (int i = 1; i <= 6; i++) send_m(24'hF00000 + 24'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_out", m_valid_out, 1'b0);
        chk("midrst_data_out",  m_data_out,  128'h0);
        chk("midrst_bits_out",  m_bits_out,  8'd0);
        chk("midrst_last_out",  m_last_out,  1'b0);
        chk("midrst_ready_in",  m_ready_in,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready_out = 1'b1;
        @(posedge clk); #1;
        m_exp_q.push_back({128'h100001_100002_100003_100004_100005_10, 8'd128, 1'b0});
        m_exp_q.push_back({16'h0006, 112'h0, 8'd16, 1'b1});
        for (int i = 1; i <= 6; i++) send_m(24'h100000 + 24'(i), 1'b0);
        // flush with no beat and fill=16 sends the padded residue
        m_flush_in = 1'b1;
        @(posedge clk); #1;
        m_flush_in = 1'b0;
        idle(3);

        // 8 -> 32: four beats make one word, then a short flushed packet
        a_exp_q.push_back({32'h12345678, 6'd32, 1'b0});
        a_exp_q.push_back({32'h9ABC0000, 6'd16, 1'b1});
        send_a(8'h12, 1'b0);
        send_a(8'h34, 1'b0);
        send_a(8'h56, 1'b0);
        send_a(8'h78, 1'b0);
        send_a(8'h9A, 1'b0);
        send_a(8'hBC, 1'b1);
        idle(3);

        // 16 -> 16: each beat is a word on the next edge
        b_exp_q.push_back({16'h1234, 5'd16, 1'b0});
        b_exp_q.push_back({16'hBEEF, 5'd16, 1'b1});
        send_b(16'h1234, 1'b0);
        @(negedge clk);
        chk("b_latency_valid_out", b_valid_out, 1'b1);
        @(posedge clk); #1;
        send_b(16'hBEEF, 1'b1);
        idle(3);

        chk("m_queue_drained", 32'(m_exp_q.size()), 32'd0);
        chk("a_queue_drained", 32'(a_exp_q.size()), 32'd0);
        chk("b_queue_drained", 32'(b_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
